// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 defaults) and the 10-bit counter type.
// Used by the pattern generator, the UART pattern-select path and vga_sync_porch.
package vga_timing_pkg;

    localparam int CNT_W            = 10;
    localparam int VIDEO_WIDTH_DEF  = 3;
    localparam int TOTAL_COLS_DEF   = 800;
    localparam int TOTAL_ROWS_DEF   = 525;
    localparam int ACTIVE_COLS_DEF  = 640;
    localparam int ACTIVE_ROWS_DEF  = 480;
    localparam int H_FRONT_PORCH_DEF = 18;
    localparam int H_BACK_PORCH_DEF  = 50;
    localparam int V_FRONT_PORCH_DEF = 10;
    localparam int V_BACK_PORCH_DEF  = 33;

    typedef logic [CNT_W-1:0] cnt_t;

    function automatic cnt_t cnt_wrap_inc(input cnt_t v, input cnt_t last);
        return (v == last) ? '0 : v + cnt_t'(1);
    endfunction

endpackage

// File: rtl/porch_frame_counter.sv
// Stage-1 sync capture plus col/row counters; a rising edge on vsync_i
// (frame start) reloads both counters to 0 regardless of their current value.
module porch_frame_counter
    import vga_timing_pkg::*;
#(
    parameter int TOTAL_COLS = TOTAL_COLS_DEF,
    parameter int TOTAL_ROWS = TOTAL_ROWS_DEF
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic hsync_i,
    input  logic vsync_i,
    output cnt_t col_o,
    output cnt_t row_o,
    output logic hsync_o,
    output logic vsync_o
);

    localparam cnt_t COL_LAST = cnt_t'(TOTAL_COLS - 1);
    localparam cnt_t ROW_LAST = cnt_t'(TOTAL_ROWS - 1);

    cnt_t col_q, col_d;
    cnt_t row_q, row_d;
    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic frame_start;

    always_comb begin
        frame_start = vsync_i && !vsync_q;
        hsync_d     = hsync_i;
        vsync_d     = vsync_i;
        col_d       = cnt_wrap_inc(col_q, COL_LAST);
        row_d       = (col_q == COL_LAST) ? cnt_wrap_inc(row_q, ROW_LAST) : row_q;
        if (frame_start) begin
            col_d = '0;
            row_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            col_q   <= '0;
            row_q   <= '0;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign col_o   = col_q;
    assign row_o   = row_q;
    assign hsync_o = hsync_q;
    assign vsync_o = vsync_q;

endmodule

// File: rtl/vga_sync_porch.sv
// Regenerates active-low VGA syncs with porches and keeps video aligned (2 stages).
// Define SYNC_PORCH_BLANK_EN to force video to 0 outside the active area.
module vga_sync_porch
    import vga_timing_pkg::*;
#(
    parameter int VIDEO_WIDTH   = VIDEO_WIDTH_DEF,
    parameter int TOTAL_COLS    = TOTAL_COLS_DEF,
    parameter int TOTAL_ROWS    = TOTAL_ROWS_DEF,
    parameter int ACTIVE_COLS   = ACTIVE_COLS_DEF,
    parameter int ACTIVE_ROWS   = ACTIVE_ROWS_DEF,
    parameter int H_FRONT_PORCH = H_FRONT_PORCH_DEF,
    parameter int H_BACK_PORCH  = H_BACK_PORCH_DEF,
    parameter int V_FRONT_PORCH = V_FRONT_PORCH_DEF,
    parameter int V_BACK_PORCH  = V_BACK_PORCH_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   Hsync_i,
    input  logic                   Vsync_i,
    input  logic [VIDEO_WIDTH-1:0] red_video_i,
    input  logic [VIDEO_WIDTH-1:0] grn_video_i,
    input  logic [VIDEO_WIDTH-1:0] blu_video_i,
    output logic                   Hsync_o,
    output logic                   Vsync_o,
    output logic [VIDEO_WIDTH-1:0] red_video_o,
    output logic [VIDEO_WIDTH-1:0] grn_video_o,
    output logic [VIDEO_WIDTH-1:0] blu_video_o
);

    localparam cnt_t H_SYNC_FIRST = cnt_t'(ACTIVE_COLS + H_FRONT_PORCH);
    localparam cnt_t H_SYNC_LAST  = cnt_t'(TOTAL_COLS - H_BACK_PORCH - 1);
    localparam cnt_t V_SYNC_FIRST = cnt_t'(ACTIVE_ROWS + V_FRONT_PORCH);
    localparam cnt_t V_SYNC_LAST  = cnt_t'(TOTAL_ROWS - V_BACK_PORCH - 1);
`ifdef SYNC_PORCH_BLANK_EN
    localparam cnt_t ACT_COLS     = cnt_t'(ACTIVE_COLS);
    localparam cnt_t ACT_ROWS     = cnt_t'(ACTIVE_ROWS);
`endif

    cnt_t col_s1;
    cnt_t row_s1;
    logic hsync_s1;
    logic vsync_s1;
    logic unused_sync_s1;

    porch_frame_counter #(
        .TOTAL_COLS (TOTAL_COLS),
        .TOTAL_ROWS (TOTAL_ROWS)
    ) u_counter (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .hsync_i (Hsync_i),
        .vsync_i (Vsync_i),
        .col_o   (col_s1),
        .row_o   (row_s1),
        .hsync_o (hsync_s1),
        .vsync_o (vsync_s1)
    );

    // Syncs are regenerated from the counters; the captured upstream levels are informational only.
    assign unused_sync_s1 = hsync_s1 ^ vsync_s1;

    logic [VIDEO_WIDTH-1:0] red_s1_q, red_s1_d;
    logic [VIDEO_WIDTH-1:0] grn_s1_q, grn_s1_d;
    logic [VIDEO_WIDTH-1:0] blu_s1_q, blu_s1_d;
    logic                   hsync_out_q, hsync_out_d;
    logic                   vsync_out_q, vsync_out_d;
    logic [VIDEO_WIDTH-1:0] red_out_q, red_out_d;
    logic [VIDEO_WIDTH-1:0] grn_out_q, grn_out_d;
    logic [VIDEO_WIDTH-1:0] blu_out_q, blu_out_d;

    always_comb begin
        red_s1_d    = red_video_i;
        grn_s1_d    = grn_video_i;
        blu_s1_d    = blu_video_i;
        hsync_out_d = !((col_s1 >= H_SYNC_FIRST) && (col_s1 <= H_SYNC_LAST));
        vsync_out_d = !((row_s1 >= V_SYNC_FIRST) && (row_s1 <= V_SYNC_LAST));
`ifdef SYNC_PORCH_BLANK_EN
        if ((col_s1 < ACT_COLS) && (row_s1 < ACT_ROWS)) begin
            red_out_d = red_s1_q;
            grn_out_d = grn_s1_q;
            blu_out_d = blu_s1_q;
        end else begin
            red_out_d = '0;
            grn_out_d = '0;
            blu_out_d = '0;
        end
`else
        red_out_d = red_s1_q;
        grn_out_d = grn_s1_q;
        blu_out_d = blu_s1_q;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            red_s1_q    <= '0;
            grn_s1_q    <= '0;
            blu_s1_q    <= '0;
            hsync_out_q <= 1'b1;
            vsync_out_q <= 1'b1;
            red_out_q   <= '0;
            grn_out_q   <= '0;
            blu_out_q   <= '0;
        end else begin
            red_s1_q    <= red_s1_d;
            grn_s1_q    <= grn_s1_d;
            blu_s1_q    <= blu_s1_d;
            hsync_out_q <= hsync_out_d;
            vsync_out_q <= vsync_out_d;
            red_out_q   <= red_out_d;
            grn_out_q   <= grn_out_d;
            blu_out_q   <= blu_out_d;
        end
    end

    assign Hsync_o     = hsync_out_q;
    assign Vsync_o     = vsync_out_q;
    assign red_video_o = red_out_q;
    assign grn_video_o = grn_out_q;
    assign blu_video_o = blu_out_q;

endmodule
